// File: rtl/mips_pkg.sv
// Shared encodings for the MEM/WB link write-back path.
// Link-mode select codes and the default link register address.
package mips_pkg;

    localparam logic [1:0] LINK_NONE = 2'b00;
    localparam logic [1:0] LINK_RA   = 2'b01;
    localparam logic [1:0] LINK_RD   = 2'b10;
    localparam logic [1:0] LINK_RSVD = 2'b11;

    localparam logic [4:0] RA = 5'd31;

endpackage

// File: rtl/link_decode.sv
// Link decode: picks write address/data/enable for link or normal writes.
// Ports: link_sel_i, pc_i, rd_i, we_i, wa_i, wd_i -> we_o, wa_o, wd_o.
module link_decode
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = int'(RA),
    parameter int LINK_OFFSET = 8
) (
    input  logic [1:0]        link_sel_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] wa_o,
    output logic [DATA_W-1:0] wd_o
);

    logic [DATA_W-1:0] link_val;
    logic              we_raw;

    // Wraps modulo 2^DATA_W.
    assign link_val = pc_i + DATA_W'(LINK_OFFSET);

    always_comb begin
        we_raw = we_i;
        wa_o   = wa_i;
        wd_o   = wd_i;
        case (link_sel_i)
            LINK_RA: begin
                we_raw = 1'b1;
                wa_o   = ADDR_W'(LINK_REG);
                wd_o   = link_val;
            end
            LINK_RD: begin
                we_raw = 1'b1;
                wa_o   = rd_i;
                wd_o   = link_val;
            end
            default: ;
        endcase
    end

    // Writes to $zero never reach the register file.
    assign we_o = we_raw & (wa_o != '0);

endmodule

// File: rtl/wb_link_stage.sv
// MEM/WB register with link write-back, write-once commit and a shadow.
// Ports: clk, reset, stall/flush, MEM inputs -> rf_*, wb_*, sh_* outputs.
module wb_link_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = int'(RA),
    parameter int LINK_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [1:0]        link_sel_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_wa_o,
    output logic [DATA_W-1:0] rf_wd_o,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_pc_o,
    output logic              sh_we_o,
    output logic [ADDR_W-1:0] sh_wa_o,
    output logic [DATA_W-1:0] sh_wd_o
);

    logic              dec_we;
    logic [ADDR_W-1:0] dec_wa;
    logic [DATA_W-1:0] dec_wd;

    link_decode #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LINK_REG   (LINK_REG),
        .LINK_OFFSET(LINK_OFFSET)
    ) u_dec (
        .link_sel_i(link_sel_i),
        .pc_i      (pc_i),
        .rd_i      (rd_i),
        .we_i      (we_i),
        .wa_i      (wa_i),
        .wd_i      (wd_i),
        .we_o      (dec_we),
        .wa_o      (dec_wa),
        .wd_o      (dec_wd)
    );

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] wa_q,    wa_d;
    logic [DATA_W-1:0] wd_q,    wd_d;
    logic              cmt_q,   cmt_d;
    logic              sh_we_q, sh_we_d;
    logic [ADDR_W-1:0] sh_wa_q, sh_wa_d;
    logic [DATA_W-1:0] sh_wd_q, sh_wd_d;

    // A held instruction writes only in its first WB cycle.
    assign rf_we_o = we_q & ~cmt_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        we_d    = we_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        cmt_d   = cmt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            pc_d    = '0;
            we_d    = 1'b0;
            wa_d    = '0;
            wd_d    = '0;
            cmt_d   = 1'b0;
        end else if (stall_i) begin
            if (rf_we_o) cmt_d = 1'b1;
        end else begin
            valid_d = in_valid_i;
            pc_d    = pc_i;
            we_d    = dec_we & in_valid_i;
            wa_d    = dec_wa;
            wd_d    = dec_wd;
            cmt_d   = 1'b0;
        end

        // Shadow tracks the write committed on this edge only.
        sh_we_d = rf_we_o;
        sh_wa_d = rf_we_o ? rf_wa_o : sh_wa_q;
        sh_wd_d = rf_we_o ? rf_wd_o : sh_wd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            cmt_q   <= 1'b0;
            sh_we_q <= 1'b0;
            sh_wa_q <= '0;
            sh_wd_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            cmt_q   <= cmt_d;
            sh_we_q <= sh_we_d;
            sh_wa_q <= sh_wa_d;
            sh_wd_q <= sh_wd_d;
        end
    end

    assign rf_wa_o    = wa_q;
    assign rf_wd_o    = wd_q;
    assign wb_valid_o = valid_q;
    assign wb_pc_o    = pc_q;
    assign sh_we_o    = sh_we_q;
    assign sh_wa_o    = sh_wa_q;
    assign sh_wd_o    = sh_wd_q;

endmodule

// File: doc/wb_link_stage.md
Name: wb_link_stage

Overview:
- Parametrised MEM/WB pipeline register that merges the link-address write-back (jal, bgezal, jalr and any future link forms) with the normal register-file write port.
- Adds stall and flush control, write-once commit under stall, and $zero write suppression.
- Adds a one-entry shadow of the last committed write, so the register file can be bypassed on the cycle after a write.
- Sits between the MEM stage and the GRF write port; replaces the purely combinational link mux.

Parameters:
- DATA_W, 32, width of data and PC.
- ADDR_W, 5, register address width.
- LINK_REG, 31, destination register for fixed-target links (jal, bgezal).
- LINK_OFFSET, 8, added to the instruction PC to form the link value (PC+8, delay slot).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the stage contents.
- flush_i  in  1  replace the incoming instruction with a bubble.
- in_valid_i  in  1  MEM-stage instruction is valid.
- pc_i  in  DATA_W  PC of the MEM-stage instruction.
- link_sel_i  in  2  link mode: 00 none, 01 LINK_REG, 10 rd, 11 reserved.
- rd_i  in  ADDR_W  rd field (jalr destination).
- we_i  in  1  normal register write enable.
- wa_i  in  ADDR_W  normal write address.
- wd_i  in  DATA_W  normal write data.
- rf_we_o  out  1  register-file write enable.
- rf_wa_o  out  ADDR_W  register-file write address.
- rf_wd_o  out  DATA_W  register-file write data.
- wb_valid_o  out  1  WB stage holds a valid instruction.
- wb_pc_o  out  DATA_W  PC of the WB instruction.
- sh_we_o  out  1  shadow entry valid.
- sh_wa_o  out  ADDR_W  shadow address.
- sh_wd_o  out  DATA_W  shadow data.

Behaviour:
- Reset, synchronous: on a clk edge with reset=1, every output register becomes 0 and the committed flag becomes 0. Reset overrides stall and flush. Reset asserted mid-stall discards the held instruction.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Link decode, applied at input:
  - link_sel_i=01: address=LINK_REG, data=pc_i+LINK_OFFSET, write enabled regardless of we_i.
  - link_sel_i=10: address=rd_i, data=pc_i+LINK_OFFSET, write enabled.
  - link_sel_i=00 or 11: address=wa_i, data=wd_i, write enable=we_i.
- Link arithmetic is modulo 2^DATA_W; wrap-around is silent (pc 0xFFFFFFFC gives 0x00000004).
- $zero suppression: a write enable with final address 0 is forced to 0. Address and data are still registered.
- Capture priority on each edge (first matching rule applies):
  1. reset.
  2. flush_i: load a bubble — valid=0, write enable=0, address, data and PC=0.
  3. stall_i: hold all contents.
  4. Otherwise: load the decoded input, valid=in_valid_i, write enable gated by in_valid_i.
- flush_i together with stall_i: flush wins.
- Write-once commit:
  - rf_we_o = stored write enable AND NOT committed.
  - committed is set on any edge where rf_we_o=1 and stall_i=1.
  - committed is cleared when new contents are loaded (normal load or flush).
  - Effect: a stalled instruction writes the register file exactly once, in its first WB cycle.
- Shadow entry:
  - On an edge with rf_we_o=1, load sh_we/sh_wa/sh_wd from rf_we_o/rf_wa_o/rf_wd_o.
  - Otherwise clear sh_we_o to 0; sh_wa_o and sh_wd_o hold.
  - Flush does not clear the shadow; it already holds a committed value.
- wb_pc_o and wb_valid_o follow the same load/hold/bubble rules as the data fields.

Decomposition:
- Shared package mips_pkg: LINK_NONE=2'b00, LINK_RA=2'b01, LINK_RD=2'b10, LINK_RSVD=2'b11, and the default register address constant RA=5'd31.
- One natural sub-module, link_decode: combinational selection of address, data and write enable from link_sel_i, plus $zero suppression.
- The stage register, commit flag and shadow stay in the top module.

Test Plan:
- jal: pc_i=0x00003000, link_sel_i=01, in_valid_i=1 -> next cycle rf_we=1, rf_wa=31, rf_wd=0x00003008; cycle after: sh_we=1, sh_wa=31, sh_wd=0x00003008.
- jalr: link_sel_i=10, rd_i=5, we_i=0, pc_i=0x00003010 -> rf_we=1, rf_wa=5, rf_wd=0x00003018. Repeat with rd_i=0 -> rf_we=0, wb_valid=1.
- Normal write: link_sel_i=00, we_i=1, wa_i=8, wd_i=0xDEADBEEF; then stall_i=1 for 3 cycles -> rf_we=1 only in the first WB cycle, 0 for the next 3; rf_wa/rf_wd stay 8 and 0xDEADBEEF; wb_valid stays 1.
- flush_i=1 and stall_i=1 on the same edge with a valid jal pending -> next cycle wb_valid=0, rf_we=0, wb_pc=0; the shadow still reflects the previous committed write.
- Link wrap: pc_i=0xFFFFFFFC, link_sel_i=01 -> rf_wd=0x00000004. Reserved link_sel_i=11, we_i=1, wa_i=3, wd_i=7 -> rf_wa=3, rf_wd=7.
- reset=1 asserted mid-stall while a write is held -> next cycle every output is 0; after reset releases, a new instruction writes normally (committed flag cleared).
